dma_copy: RTL and testbench
===========================

DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 Parameter: ADDR_WIDTH, default 16, width of all memory addresses.
REQ-002 Parameter: LEN_WIDTH, default 8, width of transfer length.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a transfer; sampled only in IDLE.
REQ-006 mode  input  1  0 = copy src->dst, 1 = fill dst with fill_value.
REQ-007 src_addr  input  ADDR_WIDTH  first source address, copy mode.
REQ-008 dst_addr  input  ADDR_WIDTH  first destination address.
REQ-009 length  input  LEN_WIDTH  byte count; 0 = no transfer.
REQ-010 fill_value  input  8  byte written in fill mode.
REQ-011 busy  output  1  high while in READ or WRITE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 mem_address  output  ADDR_WIDTH  memory address driven each cycle.
REQ-014 mem_data_out  output  8  write data to memory.
REQ-015 mem_data_in  input  8  memory read data, combinational with mem_address.
REQ-016 mem_write_enable  output  1  memory write strobe, written at next rising edge.

Function
REQ-017 The FSM SHALL have states IDLE, READ, WRITE, FINISH.
REQ-018 In IDLE with start=1 the block SHALL latch src_addr, dst_addr, length, mode, fill_value into internal registers; later input changes SHALL have no effect.
REQ-019 IDLE, start=1, length=0 SHALL go to FINISH with no memory write.
REQ-020 IDLE, start=1, length!=0 SHALL go to READ (mode 0) or WRITE (mode 1).
REQ-021 READ SHALL drive mem_address=current src, mem_write_enable=0, capture mem_data_in into a byte buffer at the edge, then go to WRITE.
REQ-022 WRITE SHALL drive mem_address=current dst, mem_write_enable=1, mem_data_out=buffer (mode 0) or fill_value (mode 1).
REQ-023 At the end of each WRITE the block SHALL increment src and dst by 1, decrement the remaining count, and go to FINISH if the count reaches 0, else READ (mode 0) or WRITE (mode 1).
REQ-024 Addresses SHALL wrap modulo 2^ADDR_WIDTH (all-ones + 1 = 0).
REQ-025 Timing: copy of N bytes SHALL take 2N cycles in READ/WRITE; fill SHALL take N cycles; done SHALL assert in the single FINISH cycle that follows, then IDLE.
REQ-026 mem_write_enable SHALL be 1 only in WRITE; in all other states mem_address SHALL hold its last value and mem_data_out SHALL be 0.
REQ-027 start SHALL be ignored outside IDLE, including in FINISH.
REQ-028 Overlapping regions SHALL be copied strictly forward byte-by-byte with no overlap detection.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE from any state, including mid-transfer, and abandon the transfer.
REQ-030 After reset: busy=0, done=0, mem_write_enable=0, mem_address=0, mem_data_out=0, buffer and count registers=0.
REQ-031 reset SHALL take priority over start in the same cycle.

Structure
REQ-032 State encoding and mode constants (MODE_COPY=0, MODE_FILL=1) SHALL be defined in the shared package.
REQ-033 The block SHALL be one module with no sub-module; the team's 16-byte on-chip ram SHALL serve as the bench memory model (address width adapted).

Verification
REQ-034 Copy: mem[0..3]=11,22,33,44; start mode 0 src=0 dst=8 len=4 -> mem[8..11]=11,22,33,44; busy high 8 cycles; done pulse 1 cycle after.
REQ-035 Fill: start mode 1 dst=4 len=3 fill_value=A5 -> mem[4..6]=A5, mem[7] unchanged; busy 3 cycles.
REQ-036 Zero length: start len=0 -> no mem_write_enable, done one cycle after start, busy never high.
REQ-037 Wrap: fill dst=FFFF len=2 value=5A -> writes at FFFF then 0000.
REQ-038 Reset mid-op: copy len=4, reset asserted in the 3rd cycle -> next cycle IDLE, busy=0, no further writes, done never pulses.
REQ-039 Busy start: start pulse during READ/WRITE with other addresses -> ignored; original transfer completes unchanged.

Source files
------------

// File: rtl/dma_copy_pkg.sv
// Shared definitions for the byte-wide DMA copy/fill engine:
// FSM state encoding and transfer mode constants.
package dma_copy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/dma_copy.sv
// Byte-serial DMA engine: copies src->dst (read/write pairs) or fills dst with a
// constant. All outputs are registered from the next-state values so they line up with the FSM.
module dma_copy
    import dma_copy_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic [7:0]            fill_value,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [7:0]            mem_data_out,
    input  logic [7:0]            mem_data_in,
    output logic                  mem_write_enable
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

    state_e                state_r, state_s;
    logic [ADDR_WIDTH-1:0] src_r, src_s, dst_r, dst_s;
    logic [LEN_WIDTH-1:0]  cnt_r, cnt_s;
    logic                  mode_r, mode_s;
    logic [7:0]            fill_r, fill_s, buf_r, buf_s;
    logic                  busy_r, done_r, we_r;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [7:0]            wdata_r, wdata_s;

    // Next-state and transfer bookkeeping; descriptor is captured only from IDLE.
    always_comb begin
        state_s = state_r;
        src_s   = src_r;
        dst_s   = dst_r;
        cnt_s   = cnt_r;
        mode_s  = mode_r;
        fill_s  = fill_r;
        buf_s   = buf_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    src_s  = src_addr;
                    dst_s  = dst_addr;
                    cnt_s  = length;
                    mode_s = mode;
                    fill_s = fill_value;
                    if (length == '0) begin
                        state_s = ST_FINISH;
                    end else if (mode == MODE_FILL) begin
                        state_s = ST_WRITE;
                    end else begin
                        state_s = ST_READ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                buf_s   = mem_data_in;
                state_s = ST_WRITE;
            end
            ST_WRITE: begin
                src_s = src_r + ADDR_ONE;
                dst_s = dst_r + ADDR_ONE;
                cnt_s = cnt_r - LEN_ONE;
                if (cnt_r == LEN_ONE) begin
                    state_s = ST_FINISH;
                end else if (mode_r == MODE_FILL) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Memory-side values for the upcoming cycle; address holds outside READ/WRITE.
    always_comb begin
        addr_s  = addr_r;
        wdata_s = 8'h00;
        case (state_s)
            ST_READ: addr_s = src_s;
            ST_WRITE: begin
                addr_s  = dst_s;
                wdata_s = (mode_s == MODE_FILL) ? fill_s : buf_s;
            end
            default: begin
                addr_s  = addr_r;
                wdata_s = 8'h00;
            end
        endcase
    end

    // State, descriptor and output registers; reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            src_r   <= '0;
            dst_r   <= '0;
            cnt_r   <= '0;
            mode_r  <= MODE_COPY;
            fill_r  <= 8'h00;
            buf_r   <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 8'h00;
        end else begin
            state_r <= state_s;
            src_r   <= src_s;
            dst_r   <= dst_s;
            cnt_r   <= cnt_s;
            mode_r  <= mode_s;
            fill_r  <= fill_s;
            buf_r   <= buf_s;
            busy_r  <= (state_s == ST_READ) || (state_s == ST_WRITE);
            done_r  <= (state_s == ST_FINISH);
            we_r    <= (state_s == ST_WRITE);
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
        end
    end

    assign busy             = busy_r;
    assign done             = done_r;
    assign mem_address      = addr_r;
    assign mem_data_out     = wdata_r;
    assign mem_write_enable = we_r;

endmodule

// File: tb/tb_dma_copy.sv
// Scoreboard bench for dma_copy: a sequential byte-array model predicts every memory
// write, a negedge monitor checks each write and the busy/done activity.
module tb_dma_copy;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset, start, mode;
    logic [15:0] src_addr, dst_addr;
    logic [7:0]  length, fill_value;
    logic        busy, done;
    logic [15:0] mem_address;
    logic [7:0]  mem_data_out, mem_data_in;
    logic        mem_write_enable;

    logic [7:0]  ram [16];
    logic [7:0]  model_mem [16];
    logic        load_req = 1'b0;
    wr_t         exp_q [$];
    int          total = 0, bad = 0;
    int          busy_total = 0, done_total = 0, cyc = 0;

    dma_copy #(.ADDR_WIDTH(16), .LEN_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_value(fill_value), .busy(busy), .done(done),
        .mem_address(mem_address), .mem_data_out(mem_data_out),
        .mem_data_in(mem_data_in), .mem_write_enable(mem_write_enable)
    );

    always #5 clk = ~clk;

    // 16-byte on-chip ram: combinational read, write on the rising edge
    assign mem_data_in = ram[mem_address[3:0]];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_req) begin
            for (int i = 0; i < 16; i++) ram[i] <= model_mem[i];
        end else if (mem_write_enable) begin
            ram[mem_address[3:0]] <= mem_data_out;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop expected writes, count busy/done cycles
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busy_total++;
            if (done) done_total++;
            if (mem_write_enable) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {16'h0, mem_address}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", {16'h0, mem_address}, {16'h0, e.a});
                    chk("wr_data", {24'h0, mem_data_out}, {24'h0, e.d});
                    chk("wr_busy", {31'h0, busy}, 32'd1);
                end
            end else if (mem_data_out !== 8'h00) begin
                chk("idle_data_zero", {24'h0, mem_data_out}, 32'd0);
            end
        end
    end

    task automatic sync_mem();
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    // Reference: forward byte-by-byte transfer over a 16-byte aliased memory
    task automatic predict(input bit m, input logic [15:0] s, input logic [15:0] d,
                           input int n, input logic [7:0] f);
        for (int i = 0; i < n; i++) begin
            logic [15:0] sa, da;
            logic [7:0]  v;
            sa = s + 16'(i);
            da = d + 16'(i);
            v  = m ? f : model_mem[sa[3:0]];
            model_mem[da[3:0]] = v;
            exp_q.push_back({da, v});
        end
    endtask

    task automatic check_mem();
        for (int i = 0; i < 16; i++) chk("mem", {24'h0, ram[i]}, {24'h0, model_mem[i]});
    endtask

    task automatic run_xfer(input bit m, input logic [15:0] s, input logic [15:0] d,
                            input logic [7:0] n, input logic [7:0] f, input bit poke);
        int b0, d0, t0, nb;
        bit got;
        predict(m, s, d, int'(n), f);
        nb = int'(n) * (m ? 1 : 2);
        b0 = busy_total;
        d0 = done_total;
        @(posedge clk); #1;
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = n; fill_value = f;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
        mode = 1'($urandom); src_addr = 16'($urandom); dst_addr = 16'($urandom);
        length = 8'($urandom); fill_value = 8'($urandom);
        if (poke && nb >= 3) begin
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("done_seen", {31'h0, got}, 32'd1);
        chk("done_latency", cyc - t0, nb);
        @(negedge clk);
        chk("done_one_cycle", {31'h0, done}, 32'd0);
        chk("busy_after", {31'h0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("busy_cycles", busy_total - b0, nb);
        chk("done_pulses", done_total - d0, 32'd1);
        chk("writes_left", exp_q.size(), 32'd0);
        check_mem();
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; mode = 1'b0; src_addr = 16'h0; dst_addr = 16'h0;
        length = 8'd5; fill_value = 8'h00;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_we", {31'h0, mem_write_enable}, 32'd0);
        chk("rst_addr", {16'h0, mem_address}, 32'd0);
        chk("rst_wdata", {24'h0, mem_data_out}, 32'd0);
        @(posedge clk); #1 reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", {31'h0, busy}, 32'd0);

        model_mem[0] = 8'h11; model_mem[1] = 8'h22; model_mem[2] = 8'h33; model_mem[3] = 8'h44;
        sync_mem();
        run_xfer(1'b0, 16'h0000, 16'h0008, 8'd4, 8'h00, 1'b0);   // copy 4 bytes
        run_xfer(1'b1, 16'h0000, 16'h0004, 8'd3, 8'hA5, 1'b0);   // fill 3 bytes
        run_xfer(1'b0, 16'h0003, 16'h0005, 8'd0, 8'h77, 1'b0);   // zero length
        run_xfer(1'b1, 16'h0000, 16'hFFFF, 8'd2, 8'h5A, 1'b0);   // address wrap
        run_xfer(1'b0, 16'h0001, 16'h0009, 8'd5, 8'h00, 1'b1);   // start while busy
        run_xfer(1'b0, 16'h0002, 16'h0003, 8'd6, 8'h00, 1'b0);   // overlapping forward copy

        // Reset during the third cycle of a 4-byte copy: only the first byte lands
        begin
            int d0;
            predict(1'b0, 16'h000A, 16'h0002, 1, 8'h00);
            d0 = done_total;
            @(posedge clk); #1;
            start = 1'b1; mode = 1'b0; src_addr = 16'h000A; dst_addr = 16'h0002; length = 8'd4;
            @(posedge clk); #1 start = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1 reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0;
            chk("mid_rst_busy", {31'h0, busy}, 32'd0);
            chk("mid_rst_done", {31'h0, done}, 32'd0);
            chk("mid_rst_we", {31'h0, mem_write_enable}, 32'd0);
            chk("mid_rst_addr", {16'h0, mem_address}, 32'd0);
            repeat (10) @(posedge clk);
            #1;
            chk("mid_rst_no_done", done_total - d0, 32'd0);
            chk("mid_rst_writes", exp_q.size(), 32'd0);
            check_mem();
        end

        for (int t = 0; t < 20; t++) begin
            run_xfer(1'($urandom), 16'($urandom), 16'($urandom),
                     8'($urandom_range(0, 20)), 8'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
